ekf_result_tx: RTL and testbench
================================

Name: ekf_result_tx

Overview:
Transmit side for the fused EKF results. It captures the six fused state words and six fused covariance diagonal words in one cycle on a start strobe, then serializes them as a framed byte stream with a valid/ready handshake. The stream feeds the board link (UART/SPI bridge) back to the host. It sits directly downstream of the EKF fusion top level and lets that block stay purely combinational.

Parameters:
SYNC0, 8'hA5, first sync byte of every frame
SYNC1, 8'h5A, second sync byte of every frame
WORD_W, 32, width of each result word; fixed at 32 for this revision (4 bytes per word)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  single-cycle capture strobe; results valid on this cycle
xf_flat  in  192  Xf0..Xf5 packed; Xf0 in [31:0], Xf5 in [191:160]
pf_flat  in  192  Pf0..Pf5 packed; Pf0 in [31:0], Pf5 in [191:160]
tx_data  out  8  current stream byte
tx_valid  out  1  tx_data is valid
tx_ready  in  1  downstream accepts the byte when tx_valid and tx_ready are both high
tx_last  out  1  high together with the checksum byte
busy  out  1  a frame is captured and not yet fully sent
overrun  out  1  sticky; set when start arrives while busy, cleared only by rst
frame_seq  out  8  sequence number of the frame in flight, or of the last frame sent

Behaviour:
- Reset values: tx_data=0, tx_valid=0, tx_last=0, busy=0, overrun=0, frame_seq=0, state=IDLE, checksum accumulator=0. A reset asserted mid-frame aborts the frame immediately: valid drops the next cycle and no partial checksum is sent.
- Frame format, 52 bytes:
  - SYNC0, SYNC1, SEQ.
  - 48 payload bytes: words in the order Xf0..Xf5 then Pf0..Pf5, each sent big-endian (bits [31:24] first).
  - CSUM = (SEQ + all 48 payload bytes) mod 256. Sync bytes are excluded from CSUM.
- FSM states: IDLE -> SYNC0 -> SYNC1 -> SEQ -> PAYLOAD -> CSUM -> IDLE.
  - A state advances only on the cycle where tx_valid && tx_ready.
  - PAYLOAD uses a 6-bit byte index 0..47. It exits to CSUM after index 47 is accepted.
- Capture: start in IDLE registers both 192-bit buses into a 384-bit shadow register. On the next cycle: tx_valid=1, tx_data=SYNC0, busy=1.
  - Latency from start to first valid byte is 1 cycle.
  - With tx_ready held high, the frame occupies 52 consecutive cycles.
- SEQ value: the frame carries the current frame_seq. frame_seq increments (mod 256, 8'hFF wraps to 8'h00) when the CSUM byte is accepted.
- Handshake rules:
  - Once tx_valid is asserted, tx_data and tx_last stay stable until accepted.
  - tx_valid never deasserts mid-frame except on rst.
  - tx_valid must not depend combinationally on tx_ready.
- Back-to-back frames: busy drops in the cycle after CSUM is accepted (state returns to IDLE).
  - A start coincident with CSUM acceptance counts as while-busy: it sets overrun and is ignored.
  - A start in the following IDLE cycle is accepted.
- Start while busy: the shadow register is not updated, the frame in flight is unaffected, and overrun is set to 1.
- Arithmetic: checksum is an 8-bit wrapping adder, cleared on entering SEQ and accumulated on each accepted SEQ and payload byte. Input data is treated as raw bits; no sign handling is needed.

Decomposition:
- Shared package ekf_pkg holds:
  - the state enum (ST_IDLE, ST_SYNC0, ST_SYNC1, ST_SEQ, ST_PAYLOAD, ST_CSUM);
  - localparams N_WORDS=12, BYTES_PER_WORD=4, PAYLOAD_BYTES=48, FRAME_BYTES=52;
  - the default sync constants.
- One natural sub-module: ekf_byte_mux, combinational. It selects payload byte k (0..47) from the 384-bit shadow register in big-endian word order. Verify it standalone.

Test Plan:
- Reset, then start with all inputs 0 and tx_ready=1. Expected bytes: A5 5A 00, then 48×00, then CSUM=00. tx_last is high only on byte 52, busy drops after it, and frame_seq becomes 1.
- xf_flat[31:0]=32'h12345678, all else 0, seq 0. Expected: bytes 4..7 = 12 34 56 78, CSUM = 0x12+0x34+0x56+0x78 = 0x14.
- pf_flat[191:160]=32'hFFFFFFFF, all else 0. Expected: bytes 48..51 = FF FF FF FF, CSUM = 0xFC. Checks Pf5 placement and wrapping of the checksum.
- tx_ready driven by a random 50% pattern. Expected: tx_data is stable while valid && !ready, there are no dropped or duplicated bytes, and the byte sequence is identical to the tx_ready=1 run.
- Second start pulse at byte 10 of a frame. Expected: the frame completes unchanged, overrun=1 and stays 1, and a later start after busy=0 sends a frame with SEQ=01.
- rst asserted at byte 20. Expected: the next cycle has tx_valid=0, busy=0, frame_seq=0, overrun=0, and a new start emits A5 5A 00 from a clean state.
- 256 back-to-back frames. Expected: SEQ runs 00..FF and then wraps to 00.

Source files
------------

// File: rtl/ekf_pkg.sv
// ekf_pkg: shared FSM state enum, frame geometry and default sync bytes for the EKF result transmitter
package ekf_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_SYNC0, ST_SYNC1, ST_SEQ, ST_PAYLOAD, ST_CSUM} state_t;
  localparam int N_WORDS = 12;
  localparam int BYTES_PER_WORD = 4;
  localparam int PAYLOAD_BYTES = 48;
  localparam int FRAME_BYTES = 52;
  localparam int SHADOW_W = N_WORDS * 32;
  localparam logic [7:0] SYNC0_DEFAULT = 8'hA5;
  localparam logic [7:0] SYNC1_DEFAULT = 8'h5A;
endpackage

// File: rtl/ekf_byte_mux.sv
// ekf_byte_mux: picks payload byte k (0..47, big-endian within each 32-bit word) from shadow; in shadow[383:0], k[5:0]; out b[7:0]
module ekf_byte_mux
  import ekf_pkg::*;
(
  input  logic [SHADOW_W-1:0] shadow,
  input  logic [5:0]          k,
  output logic [7:0]          b
);
  logic [8:0] off;
  always_comb begin
    off = {k[5:2], 5'b0} + {4'b0, ~k[1:0], 3'b0};
    b = (k[5:4] == 2'b11) ? 8'h00 : shadow[off +: 8];
  end
endmodule

// File: rtl/ekf_result_tx.sv
// ekf_result_tx: captures Xf/Pf on start and streams A5 5A SEQ payload CSUM with valid/ready; in clk rst start xf_flat pf_flat tx_ready; out tx_data tx_valid tx_last busy overrun frame_seq
module ekf_result_tx
  import ekf_pkg::*;
#(
  parameter logic [7:0] SYNC0 = SYNC0_DEFAULT,
  parameter logic [7:0] SYNC1 = SYNC1_DEFAULT,
  parameter int WORD_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [6*WORD_W-1:0] xf_flat,
  input  logic [6*WORD_W-1:0] pf_flat,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic                tx_last,
  output logic                busy,
  output logic                overrun,
  output logic [7:0]          frame_seq
);
  state_t state, state_n;
  logic [N_WORDS*WORD_W-1:0] shadow;
  logic [5:0] idx;
  logic [7:0] csum, pay;
  logic acc;
  ekf_byte_mux u_mux (.shadow(shadow), .k(idx), .b(pay));
  assign tx_valid = state != ST_IDLE;
  assign busy = tx_valid;
  assign tx_last = state == ST_CSUM;
  assign tx_data = state == ST_SYNC0   ? SYNC0 :
                   state == ST_SYNC1   ? SYNC1 :
                   state == ST_SEQ     ? frame_seq :
                   state == ST_PAYLOAD ? pay :
                   state == ST_CSUM    ? csum : 8'h00;
  always_comb begin
    state_n = state;
    acc = tx_valid && tx_ready;
    case (state)
      ST_IDLE:    state_n = start ? ST_SYNC0 : ST_IDLE;
      ST_SYNC0:   state_n = acc ? ST_SYNC1 : ST_SYNC0;
      ST_SYNC1:   state_n = acc ? ST_SEQ : ST_SYNC1;
      ST_SEQ:     state_n = acc ? ST_PAYLOAD : ST_SEQ;
      ST_PAYLOAD: state_n = (acc && idx == 6'(PAYLOAD_BYTES - 1)) ? ST_CSUM : ST_PAYLOAD;
      ST_CSUM:    state_n = acc ? ST_IDLE : ST_CSUM;
      default:    state_n = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      shadow <= '0;
      idx <= '0;
      csum <= '0;
      frame_seq <= '0;
      overrun <= 1'b0;
    end else begin
      state <= state_n;
      if (state == ST_IDLE && start) shadow <= {pf_flat, xf_flat};
      if (busy && start) overrun <= 1'b1;
      if (acc) begin
        idx <= state == ST_PAYLOAD ? idx + 6'd1 : 6'd0;
        csum <= state == ST_SYNC1 ? 8'h00 :
                (state == ST_SEQ || state == ST_PAYLOAD) ? csum + tx_data : csum;
        frame_seq <= state == ST_CSUM ? frame_seq + 8'd1 : frame_seq;
      end
    end
  end
endmodule

// File: tb/tb_ekf_result_tx.sv
// tb_ekf_result_tx: directed self-checking bench for ekf_result_tx and ekf_byte_mux
module tb_ekf_result_tx;
  logic clk = 0, rst = 1, start = 0, tx_ready = 0;
  logic [191:0] xf = '0, pf = '0;
  logic [7:0] tx_data, frame_seq;
  logic tx_valid, tx_last, busy, overrun;
  logic [383:0] m_shadow;
  logic [5:0] m_k;
  logic [7:0] m_b;
  logic [7:0] got [52];
  logic [7:0] exp_f [52];
  logic [7:0] ref_f [52];
  int n_got, last_cnt, last_pos;
  int n_tests = 0, n_fail = 0;
  logic [191:0] x, p;
  ekf_result_tx dut (
    .clk(clk), .rst(rst), .start(start), .xf_flat(xf), .pf_flat(pf),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_last(tx_last),
    .busy(busy), .overrun(overrun), .frame_seq(frame_seq)
  );
  ekf_byte_mux u_mux (.shadow(m_shadow), .k(m_k), .b(m_b));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask
  function automatic void build(input logic [7:0] seq, input logic [191:0] xv, input logic [191:0] pv);
    logic [383:0] all;
    logic [7:0] s;
    all = {pv, xv};
    exp_f[0] = 8'hA5;
    exp_f[1] = 8'h5A;
    exp_f[2] = seq;
    s = seq;
    for (int w = 0; w < 12; w++)
      for (int b = 0; b < 4; b++) begin
        exp_f[3 + 4*w + b] = all[w*32 + 24 - 8*b +: 8];
        s += exp_f[3 + 4*w + b];
      end
    exp_f[51] = s;
  endfunction
  function automatic int diff_exp();
    int d = 0;
    for (int i = 0; i < 52; i++) if (got[i] !== exp_f[i]) d++;
    return d;
  endfunction
  function automatic int diff_ref();
    int d = 0;
    for (int i = 0; i < 52; i++) if (got[i] !== ref_f[i]) d++;
    return d;
  endfunction
  task automatic reset_dut();
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask
  task automatic do_start(input logic [191:0] xv, input logic [191:0] pv);
    xf = xv;
    pf = pv;
    start = 1;
    @(negedge clk);
    start = 0;
  endtask
  task automatic collect(input bit rnd, input int start_at, input int abort_at);
    logic [7:0] pd;
    logic pvld, prdy, pl;
    int cyc;
    n_got = 0; last_cnt = 0; last_pos = -1; cyc = 0;
    pd = 0; pvld = 0; prdy = 0; pl = 0;
    while (n_got < 52 && n_got != abort_at && cyc < 1000) begin
      tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start = (n_got == start_at) && tx_ready && tx_valid;
      if (pvld && !prdy) begin
        check("hold_valid", 32'(tx_valid), 1);
        check("hold_data", 32'(tx_data), 32'(pd));
        check("hold_last", 32'(tx_last), 32'(pl));
      end
      if (tx_valid && tx_ready) begin
        got[n_got] = tx_data;
        if (tx_last) begin last_cnt++; last_pos = n_got; end
        n_got++;
      end
      pvld = tx_valid; prdy = tx_ready; pd = tx_data; pl = tx_last;
      cyc++;
      @(negedge clk);
    end
    start = 0;
    check("frame_len", n_got, abort_at < 0 ? 52 : abort_at);
  endtask
  task automatic frame_check(input string tag);
    check({tag, "_bytes"}, diff_exp(), 0);
    check({tag, "_last_cnt"}, last_cnt, 1);
    check({tag, "_last_pos"}, last_pos, 51);
    check({tag, "_busy_after"}, 32'(busy), 0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(tx_valid), 0);
    check("rst_data", 32'(tx_data), 0);
    check("rst_last", 32'(tx_last), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_seq", 32'(frame_seq), 0);
    rst = 0;
    build(8'h00, '0, '0);
    do_start('0, '0);
    check("lat_valid", 32'(tx_valid), 1);
    check("lat_data", 32'(tx_data), 32'hA5);
    check("lat_busy", 32'(busy), 1);
    collect(0, -1, -1);
    frame_check("zero");
    check("zero_csum", 32'(got[51]), 0);
    check("zero_seq_after", 32'(frame_seq), 1);
    reset_dut();
    x = 192'h12345678;
    build(8'h00, x, '0);
    do_start(x, '0);
    collect(0, -1, -1);
    frame_check("xf0");
    check("xf0_word", {got[3], got[4], got[5], got[6]}, 32'h12345678);
    check("xf0_csum", 32'(got[51]), 32'h14);
    reset_dut();
    p = {32'hFFFFFFFF, 160'h0};
    build(8'h00, '0, p);
    do_start('0, p);
    collect(0, -1, -1);
    frame_check("pf5");
    check("pf5_word", {got[47], got[48], got[49], got[50]}, 32'hFFFFFFFF);
    check("pf5_csum", 32'(got[51]), 32'hFC);
    x = 192'h0123456789ABCDEF_DEADBEEFCAFEF00D_1122334455667788;
    p = 192'h99AABBCCDDEEFF00_0F1E2D3C4B5A6978_8796A5B4C3D2E1F0;
    reset_dut();
    build(8'h00, x, p);
    do_start(x, p);
    collect(0, -1, -1);
    frame_check("full");
    ref_f = got;
    reset_dut();
    do_start(x, p);
    collect(1, -1, -1);
    frame_check("rand");
    check("rand_vs_full", diff_ref(), 0);
    reset_dut();
    build(8'h00, x, p);
    do_start(x, p);
    xf = ~x;
    collect(0, 10, -1);
    frame_check("ovr");
    check("ovr_set", 32'(overrun), 1);
    repeat (3) @(negedge clk);
    check("ovr_sticky", 32'(overrun), 1);
    check("ovr_idle_busy", 32'(busy), 0);
    build(8'h01, ~x, p);
    do_start(~x, p);
    collect(0, -1, -1);
    frame_check("ovr_next");
    check("ovr_next_seq", 32'(got[2]), 1);
    check("ovr_still", 32'(overrun), 1);
    do_start(x, p);
    collect(0, -1, 20);
    rst = 1;
    @(negedge clk);
    check("abort_valid", 32'(tx_valid), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_last", 32'(tx_last), 0);
    check("abort_seq", 32'(frame_seq), 0);
    check("abort_overrun", 32'(overrun), 0);
    rst = 0;
    build(8'h00, x, p);
    do_start(x, p);
    collect(0, -1, -1);
    frame_check("post_abort");
    check("post_abort_hdr", {8'h00, got[0], got[1], got[2]}, 32'h00A55A00);
    reset_dut();
    build(8'h00, x, p);
    do_start(x, p);
    collect(0, 51, -1);
    frame_check("coinc");
    check("coinc_overrun", 32'(overrun), 1);
    @(negedge clk);
    check("coinc_ignored", 32'(busy), 0);
    reset_dut();
    for (int i = 0; i < 257; i++) begin
      do_start(x, p);
      collect(0, -1, -1);
      check("bb_seq", 32'(got[2]), i % 256);
    end
    check("bb_seq_final", 32'(frame_seq), 1);
    check("bb_overrun", 32'(overrun), 0);
    m_shadow = '0;
    for (int w = 0; w < 12; w++)
      for (int b = 0; b < 4; b++) m_shadow[w*32 + 24 - 8*b +: 8] = 8'(4*w + b);
    begin
      int d = 0;
      for (int k = 0; k < 48; k++) begin
        m_k = 6'(k);
        #1;
        if (m_b !== 8'(k)) d++;
      end
      check("mux_all", d, 0);
    end
    m_shadow = '0;
    m_shadow[31:24] = 8'hC3;
    m_shadow[383:376] = 8'h3C;
    m_k = 6'd0;
    #1;
    check("mux_first", 32'(m_b), 32'hC3);
    m_k = 6'd44;
    #1;
    check("mux_pf5_msb", 32'(m_b), 32'h3C);
    m_k = 6'd47;
    #1;
    check("mux_last", 32'(m_b), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
